// File: rtl/stepper_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : stepper_phase_monitor
// Description : Receive-side checker for an 8-state half-step stepper coil
//               sequence. Synchronises the coil pattern and decodes it to a
//               phase. Tracks signed position and direction, reports the end
//               of each move, and flags illegal or skipped patterns.
// Ports       : clk, rst (async, active-high)
//               coil[3:0]      observed coil pattern (may be asynchronous)
//               clr_pos        pulse: clear position
//               clr_fault      pulse: clear sticky fault
//               phase[2:0]     phase of last valid pattern
//               valid_pat      synced pattern is a legal code
//               position       signed step count (wraps)
//               dir            direction of last step (1 = forward)
//               moving         a move is in progress
//               step_pulse     one pulse per accepted step
//               move_done      one pulse at the end of a move
//               move_steps     step count of the last completed move
//               fault          sticky fault flag
//               fault_code     01 illegal pattern, 10 skipped phase
// Revision    : 1.0  initial release
// ============================================================================
module stepper_phase_monitor #(
    parameter int STEP_TIMEOUT = 250000,
    parameter int POS_W        = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       coil,
    input  logic             clr_pos,
    input  logic             clr_fault,
    output logic [2:0]       phase,
    output logic             valid_pat,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             moving,
    output logic             step_pulse,
    output logic             move_done,
    output logic [POS_W-1:0] move_steps,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int                c_tmr_w    = $clog2(STEP_TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(STEP_TIMEOUT - 1);
    // Driver idle pattern; the sync chain starts here so leaving reset with
    // the motor parked produces no spurious event.
    localparam logic [3:0]        c_idle_pat = 4'b1000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_done;

    logic [3:0]           r_sync [SYNC_STAGES];
    logic [3:0]           r_prev;
    logic [3:0]           w_cur;
    logic                 w_legal;
    logic [2:0]           w_new_ph;
    logic [2:0]           w_d;
    logic                 w_change;
    logic                 w_fwd;
    logic                 w_rev;
    logic                 w_step;
    logic                 w_snap;
    logic                 w_skip;
    logic                 w_illegal;
    logic                 w_fault_ev;
    logic [1:0]           w_fault_code_ev;

    logic [2:0]           r_last_valid;
    logic                 r_valid_pat;
    logic [POS_W-1:0]     r_position;
    logic                 r_dir;
    logic                 r_step_pulse;
    logic                 r_move_done;
    logic [POS_W-1:0]     r_move_steps;
    logic [POS_W-1:0]     r_count;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_fault;
    logic [1:0]           r_fault_code;

    // ------------------------------------------------------------------
    // Input synchroniser plus one extra register for change detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= c_idle_pat;
            end
            r_prev <= c_idle_pat;
        end else begin
            r_sync[0] <= coil;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_cur    = r_sync[SYNC_STAGES-1];
    assign w_change = (w_cur != r_prev);

    // ------------------------------------------------------------------
    // Pattern decode
    // ------------------------------------------------------------------
    always_comb begin
        w_legal  = 1'b1;
        w_new_ph = 3'd0;
        case (w_cur)
            4'b1000: w_new_ph = 3'd0;
            4'b1100: w_new_ph = 3'd1;
            4'b0100: w_new_ph = 3'd2;
            4'b0110: w_new_ph = 3'd3;
            4'b0010: w_new_ph = 3'd4;
            4'b0011: w_new_ph = 3'd5;
            4'b0001: w_new_ph = 3'd6;
            4'b1001: w_new_ph = 3'd7;
            default: w_legal  = 1'b0;
        endcase
    end

    // Phase distance wraps naturally in 3 bits (mod 8).
    assign w_d       = w_new_ph - r_last_valid;
    assign w_fwd     = w_change && w_legal && (w_d == 3'd1);
    assign w_rev     = w_change && w_legal && (w_d == 3'd7);
    assign w_step    = w_fwd || w_rev;
    // Jump back to the idle pattern from any non-adjacent phase is the
    // driver parking the motor, not a skipped step.
    assign w_snap    = w_change && w_legal && (w_new_ph == 3'd0) &&
                       (w_d >= 3'd2) && (w_d <= 3'd6);
    assign w_skip    = w_change && w_legal && !w_step && !w_snap;
    assign w_illegal = w_change && !w_legal;

    assign w_fault_ev      = w_skip || w_illegal;
    assign w_fault_code_ev = w_illegal ? 2'b01 : 2'b10;

    // ------------------------------------------------------------------
    // Move FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_step) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A step in the timeout cycle keeps the move alive.
                if (!w_step && (w_snap || (r_timer == c_tmr_last))) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Position, phase and move bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_valid <= 3'd0;
            r_valid_pat  <= 1'b0;
            r_position   <= '0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_move_done  <= 1'b0;
            r_move_steps <= '0;
            r_count      <= '0;
            r_timer      <= '0;
        end else begin
            r_valid_pat  <= w_legal;
            r_step_pulse <= w_step;
            r_move_done  <= w_done;

            if (w_change && w_legal) begin
                r_last_valid <= w_new_ph;
            end

            if (clr_pos) begin
                r_position <= '0;
            end else if (w_fwd) begin
                r_position <= r_position + 1'b1;
            end else if (w_rev) begin
                r_position <= r_position - 1'b1;
            end

            if (w_step) begin
                r_dir <= w_fwd;
            end

            if (w_step) begin
                r_timer <= '0;
                if (r_state == ST_IDLE) begin
                    r_count <= POS_W'(1);
                end else if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (r_state == ST_RUN) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_done) begin
                r_move_steps <= r_count;
                r_timer      <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault: first code wins; a new fault beats a same-cycle clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else if (w_fault_ev && (!r_fault || clr_fault)) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code_ev;
        end else if (clr_fault) begin
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end
    end

    assign phase      = r_last_valid;
    assign valid_pat  = r_valid_pat;
    assign position   = r_position;
    assign dir        = r_dir;
    assign moving     = (r_state == ST_RUN);
    assign step_pulse = r_step_pulse;
    assign move_done  = r_move_done;
    assign move_steps = r_move_steps;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_phase_monitor
// Description : Self-checking bench for stepper_phase_monitor. A cycle-level
//               reference model computes expected outputs from phase arithmetic
//               and move bookkeeping by cycle number.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stepper_phase_monitor;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  coil;
    logic        clr_pos;
    logic        clr_fault;
    logic [2:0]  phase;
    logic        valid_pat;
    logic [15:0] position;
    logic        dir;
    logic        moving;
    logic        step_pulse;
    logic        move_done;
    logic [15:0] move_steps;
    logic        fault;
    logic [1:0]  fault_code;

    stepper_phase_monitor #(
        .STEP_TIMEOUT(TO),
        .POS_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coil       (coil),
        .clr_pos    (clr_pos),
        .clr_fault  (clr_fault),
        .phase      (phase),
        .valid_pat  (valid_pat),
        .position   (position),
        .dir        (dir),
        .moving     (moving),
        .step_pulse (step_pulse),
        .move_done  (move_done),
        .move_steps (move_steps),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] pat_tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // Reference model state
    logic [3:0]  h1, h2, m_prev_pat;
    int          m_last;
    logic [15:0] m_pos;
    logic        m_dir, m_fault, m_run, m_valid;
    logic [1:0]  m_code;
    int          m_count, m_steps, m_cyc, m_last_step_cyc;
    int          obs_steps, obs_dones;

    function automatic int ph_of(input logic [3:0] p);
        for (int i = 0; i < 8; i++) begin
            if (pat_tbl[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        h1 = 4'b1000; h2 = 4'b1000; m_prev_pat = 4'b1000;
        m_last = 0; m_pos = '0; m_dir = 0; m_fault = 0; m_code = 0;
        m_run = 0; m_valid = 1; m_count = 0; m_steps = 0;
        m_cyc = 0; m_last_step_cyc = 0;
        obs_steps = 0; obs_dones = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; coil = 4'b1000; clr_pos = 0; clr_fault = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cyc(input logic [3:0] c, input logic cp, input logic cf);
        logic [3:0] eff;
        int ph, d;
        logic step, fwd, snap, fev, e_done;
        logic [1:0] fc;
        @(negedge clk);
        coil = c; clr_pos = cp; clr_fault = cf;
        @(posedge clk);
        #1;
        clr_pos = 0; clr_fault = 0;
        m_cyc++;
        // Pattern reaches the evaluator two drive-slots later.
        eff = h2; h2 = h1; h1 = c;
        step = 0; fwd = 0; snap = 0; fev = 0; fc = 2'b00; e_done = 0;
        ph = ph_of(eff);
        if (eff !== m_prev_pat) begin
            if (ph < 0) begin
                fev = 1; fc = 2'b01;
            end else begin
                d = (ph - m_last + 8) % 8;
                if (d == 1) begin step = 1; fwd = 1; end
                else if (d == 7) step = 1;
                else if (ph == 0 && d != 0) snap = 1;
                else begin fev = 1; fc = 2'b10; end
                m_last = ph;
            end
        end
        m_prev_pat = eff;
        m_valid = (ph >= 0);
        if (cp) m_pos = '0;
        else if (step) m_pos = m_pos + (fwd ? 16'd1 : 16'hFFFF);
        if (step) m_dir = fwd;
        if (fev && (!m_fault || cf)) begin m_fault = 1; m_code = fc; end
        else if (cf) begin m_fault = 0; m_code = 0; end
        if (step) begin
            if (!m_run) begin m_run = 1; m_count = 1; end
            else if (m_count < 65535) m_count++;
            m_last_step_cyc = m_cyc;
        end else if (m_run && (snap || (m_cyc - m_last_step_cyc == TO))) begin
            e_done = 1; m_steps = m_count; m_run = 0;
        end
        obs_steps += int'(step_pulse);
        obs_dones += int'(move_done);

        checks++; if (step_pulse !== step) begin errors++; $display("FAIL step_pulse cyc=%0d got=%b exp=%b", m_cyc, step_pulse, step); end
        checks++; if (move_done !== e_done) begin errors++; $display("FAIL move_done cyc=%0d got=%b exp=%b", m_cyc, move_done, e_done); end
        checks++; if (position !== m_pos) begin errors++; $display("FAIL position cyc=%0d got=%h exp=%h", m_cyc, position, m_pos); end
        checks++; if (dir !== m_dir) begin errors++; $display("FAIL dir cyc=%0d got=%b exp=%b", m_cyc, dir, m_dir); end
        checks++; if (fault !== m_fault) begin errors++; $display("FAIL fault cyc=%0d got=%b exp=%b", m_cyc, fault, m_fault); end
        checks++; if (fault_code !== m_code) begin errors++; $display("FAIL fault_code cyc=%0d got=%b exp=%b", m_cyc, fault_code, m_code); end
        checks++; if (valid_pat !== m_valid) begin errors++; $display("FAIL valid_pat cyc=%0d got=%b exp=%b", m_cyc, valid_pat, m_valid); end
        checks++; if (phase !== 3'(m_last)) begin errors++; $display("FAIL phase cyc=%0d got=%0d exp=%0d", m_cyc, phase, m_last); end
        checks++; if (moving !== m_run) begin errors++; $display("FAIL moving cyc=%0d got=%b exp=%b", m_cyc, moving, m_run); end
        checks++; if (move_steps !== 16'(m_steps)) begin errors++; $display("FAIL move_steps cyc=%0d got=%0d exp=%0d", m_cyc, move_steps, m_steps); end
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) cyc(c, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; coil = 4'b1000; clr_pos = 0; clr_fault = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({phase, valid_pat, position, dir, moving, step_pulse, move_done, move_steps, fault, fault_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pos=%h phase=%0d vp=%b mv=%b fault=%b exp all zero", position, phase, valid_pat, moving, fault);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(4'b1000, 3);
    endtask

    task automatic test_forward();
        do_reset();
        for (int i = 1; i <= 16; i++) hold(pat_tbl[i % 8], 10);
        hold(pat_tbl[0], 60);
        checks++; if (obs_steps != 16) begin errors++; $display("FAIL fwd_step_count got=%0d exp=16", obs_steps); end
        checks++; if (obs_dones != 1) begin errors++; $display("FAIL fwd_done_count got=%0d exp=1", obs_dones); end
        checks++; if (position !== 16'd16) begin errors++; $display("FAIL fwd_position got=%0d exp=16", position); end
        checks++; if (move_steps !== 16'd16) begin errors++; $display("FAIL fwd_move_steps got=%0d exp=16", move_steps); end
    endtask

    task automatic test_reverse();
        logic [3:0] seq [5] = '{4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        do_reset();
        for (int i = 0; i < 5; i++) hold(seq[i], 5);
        checks++; if (position !== 16'hFFFB) begin errors++; $display("FAIL rev_position got=%h exp=fffb", position); end
        checks++; if (dir !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rev_dir_fault got dir=%b fault=%b exp dir=0 fault=0", dir, fault); end
    endtask

    task automatic test_snap();
        do_reset();
        for (int i = 1; i <= 13; i++) hold(pat_tbl[i % 8], 4);
        hold(4'b1000, 6);
        checks++; if (position !== 16'd13 || fault !== 1'b0) begin errors++; $display("FAIL snap_pos got=%0d fault=%b exp 13 0", position, fault); end
        checks++; if (move_steps !== 16'd13 || moving !== 1'b0) begin errors++; $display("FAIL snap_move got steps=%0d moving=%b exp 13 0", move_steps, moving); end
        checks++; if (obs_dones != 1) begin errors++; $display("FAIL snap_done_count got=%0d exp=1", obs_dones); end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int i = 1; i <= 3; i++) hold(pat_tbl[i], 4);
        hold(4'b1111, 5);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01 || valid_pat !== 1'b0) begin errors++; $display("FAIL illegal_flag got f=%b c=%b vp=%b exp 1 01 0", fault, fault_code, valid_pat); end
        checks++; if (position !== 16'd3) begin errors++; $display("FAIL illegal_hold got=%0d exp=3", position); end
        hold(pat_tbl[4], 5);
        checks++; if (position !== 16'd4) begin errors++; $display("FAIL illegal_resume got=%0d exp=4", position); end
        cyc(pat_tbl[4], 0, 1);
        hold(pat_tbl[4], 2);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clr_fault got=%b exp=0", fault); end
    endtask

    task automatic test_skip();
        do_reset();
        hold(4'b1100, 5);
        hold(4'b0110, 5);
        checks++; if (fault_code !== 2'b10 || position !== 16'd1) begin errors++; $display("FAIL skip got c=%b pos=%0d exp 10 1", fault_code, position); end
        hold(4'b0101, 5);
        checks++; if (fault_code !== 2'b10) begin errors++; $display("FAIL skip_sticky got=%b exp=10", fault_code); end
    endtask

    task automatic test_clr_pos();
        do_reset();
        for (int i = 1; i <= 3; i++) hold(pat_tbl[i], 4);
        cyc(pat_tbl[4], 0, 0);
        cyc(pat_tbl[4], 0, 0);
        cyc(pat_tbl[4], 1, 0);
        checks++; if (step_pulse !== 1'b1 || position !== 16'd0) begin errors++; $display("FAIL clr_pos_step got sp=%b pos=%0d exp 1 0", step_pulse, position); end
        hold(pat_tbl[4], 3);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 1; i <= 4; i++) hold(pat_tbl[i], 4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({phase, valid_pat, position, dir, moving, step_pulse, move_done, move_steps, fault, fault_code} !== '0) begin
            errors++;
            $display("FAIL async_reset got pos=%h phase=%0d mv=%b dir=%b exp all zero", position, phase, moving, dir);
        end
        @(negedge clk);
        coil = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(4'b1000, 60);
        checks++; if (obs_dones != 0) begin errors++; $display("FAIL async_no_done got=%0d exp=0", obs_dones); end
    endtask

    task automatic test_random();
        int drv_ph, r, n;
        logic [3:0] p;
        do_reset();
        drv_ph = 0;
        p = 4'b1000;
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin drv_ph = (drv_ph + 1) % 8; p = pat_tbl[drv_ph]; end
            else if (r < 70) begin drv_ph = (drv_ph + 7) % 8; p = pat_tbl[drv_ph]; end
            else if (r < 78) begin drv_ph = 0; p = pat_tbl[0]; end
            else if (r < 86) begin
                p = 4'($urandom_range(0, 15));
                while (ph_of(p) >= 0) p = 4'($urandom_range(0, 15));
            end else if (r < 94) begin drv_ph = $urandom_range(0, 7); p = pat_tbl[drv_ph]; end
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 15);
            for (int k = 0; k < n; k++) begin
                cyc(p, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_snap();
        test_illegal();
        test_skip();
        test_clr_pos();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
